// File: rtl/apb_master_fsm.sv
// rtl/apb_master_fsm.sv - APB master FSM (IDLE/SETUP/ACCESS) for the AHB-to-APB bridge
// Optional ACCESS wait-state timeout is built when APB_TIMEOUT_EN is defined.
module apb_master_fsm #(
  parameter int APB_BUS_W   = 32,
  parameter int APB_ADDR_W  = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [APB_ADDR_W-1:0] req_addr,
  input  logic                  req_write,
  input  logic [APB_BUS_W-1:0]  req_wdata,
  output logic                  rsp_valid,
  output logic [APB_BUS_W-1:0]  rsp_rdata,
  output logic                  rsp_err,
  output logic [APB_ADDR_W-1:0] paddr,
  output logic                  pwrite,
  output logic [APB_BUS_W-1:0]  pwdata,
  output logic                  psel,
  output logic                  penable,
  input  logic [APB_BUS_W-1:0]  prdata,
  input  logic                  pready
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..255");
  end

  assign req_ready = (state == IDLE);

`ifdef APB_TIMEOUT_EN
  // The abort fires on the edge where the count would reach the limit.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wait_cnt;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
`ifdef APB_TIMEOUT_EN
      rsp_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_valid) begin
            paddr  <= req_addr;
            pwrite <= req_write;
            pwdata <= req_write ? req_wdata : '0;
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (pready) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= pwrite ? '0 : prdata;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_fsm.sv
// tb/tb_apb_master_fsm.sv - self-checking bench for apb_master_fsm
// Timeout scenarios are exercised when APB_TIMEOUT_EN is defined.
module tb_apb_master_fsm;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        psel;
  logic        penable;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  apb_master_fsm #(.APB_BUS_W(32), .APB_ADDR_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request from IDLE and checks every cycle until its response.
  // Expected behaviour: SETUP one cycle, ACCESS for waits+1 cycles (or the
  // timeout limit when enabled), then a one-cycle response.
  task automatic run_xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input logic [31:0] rd, input int waits, input bit hold_next,
                          output int acc_cyc);
    int  n_acc;
    bit  aborted;
    logic [31:0] exp_wd;
    n_acc   = waits + 1;
    aborted = 1'b0;
`ifdef APB_TIMEOUT_EN
    if (waits >= TMO) begin
      n_acc   = TMO;
      aborted = 1'b1;
    end
`endif
    exp_wd = w ? wd : 32'h0;
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = wd;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL idle_ready got=%b exp=1", req_ready);
    end
    step();
    acc_cyc = cyc;
    if (!hold_next) req_valid = 1'b0;
    pready = 1'($urandom);
    total++;
    if ({psel, penable, req_ready, rsp_valid} !== 4'b1000) begin
      bad++; $display("FAIL setup_ctl got=%b exp=1000", {psel, penable, req_ready, rsp_valid});
    end
    total++;
    if ({paddr, pwrite, pwdata} !== {a, w, exp_wd}) begin
      bad++; $display("FAIL setup_bus got=%h/%b/%h exp=%h/%b/%h", paddr, pwrite, pwdata, a, w, exp_wd);
    end
    step();
    for (int i = 0; i < n_acc; i++) begin
      total++;
      if ({psel, penable, req_ready, rsp_valid, paddr, pwrite, pwdata} !== {4'b1100, a, w, exp_wd}) begin
        bad++;
        $display("FAIL access_%0d got=%b %h/%b/%h exp=1100 %h/%b/%h", i,
                 {psel, penable, req_ready, rsp_valid}, paddr, pwrite, pwdata, a, w, exp_wd);
      end
      pready = (!aborted && i == waits);
      prdata = (i == waits) ? rd : $urandom;
      step();
    end
    pready = 1'b0;
    prdata = $urandom;
    total++;
    if ({rsp_valid, rsp_err, psel, penable, req_ready} !== {1'b1, aborted, 3'b001}) begin
      bad++;
      $display("FAIL rsp_ctl got=%b exp=%b", {rsp_valid, rsp_err, psel, penable, req_ready},
               {1'b1, aborted, 3'b001});
    end
    total++;
    if (rsp_rdata !== ((w || aborted) ? 32'h0 : rd)) begin
      bad++; $display("FAIL rsp_rdata got=%h exp=%h", rsp_rdata, (w || aborted) ? 32'h0 : rd);
    end
    if (!hold_next) begin
      step();
      total++;
      if ({rsp_valid, psel, req_ready} !== 3'b001) begin
        bad++; $display("FAIL rsp_pulse got=%b exp=001", {rsp_valid, psel, req_ready});
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b1; req_addr = 32'hFFFF_FFFF; req_write = 1'b1;
    req_wdata = 32'hFFFF_FFFF; pready = 1'b1;
    repeat (3) step();
    total++;
    if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      bad++; $display("FAIL reset_outs got psel=%b penable=%b paddr=%h rsp_valid=%b exp=all0",
                      psel, penable, paddr, rsp_valid);
    end
    req_valid = 1'b0; pready = 1'b0;
    reset_n = 1'b1;
    step();
    total++;
    if ({req_ready, psel} !== 2'b10) begin
      bad++; $display("FAIL reset_release got=%b exp=10", {req_ready, psel});
    end
  endtask

  task automatic test_zero_wait_write();
    int t;
    run_xfer(32'h0000_0040, 1'b1, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, t);
  endtask

  task automatic test_wait_read();
    int t;
    run_xfer(32'h0000_0010, 1'b0, 32'hAAAA_5555, 32'h1234_5678, 3, 1'b0, t);
  endtask

  task automatic test_random();
    int t;
    for (int k = 0; k < 12; k++)
      run_xfer($urandom, 1'($urandom), $urandom, $urandom, int'($urandom_range(0, 6)), 1'b0, t);
  endtask

  task automatic test_back_to_back();
    int prev;
    int now;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      run_xfer(32'h100 + 32'(k * 4), 1'(k), $urandom, $urandom, 0, (k != 3), now);
      if (k > 0) begin
        total++;
        if (now - prev !== 3) begin
          bad++; $display("FAIL b2b_interval got=%0d exp=3", now - prev);
        end
      end
      prev = now;
    end
  endtask

  task automatic test_reset_mid();
    int t;
    req_valid = 1'b1; req_addr = 32'h0000_0200; req_write = 1'b1; req_wdata = 32'h5A5A_5A5A;
    pready = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    step();
    total++;
    if ({psel, penable} !== 2'b11) begin
      bad++; $display("FAIL mid_access got=%b exp=11", {psel, penable});
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err} !== '0) begin
      bad++; $display("FAIL mid_reset_async got psel=%b penable=%b paddr=%h exp=0", psel, penable, paddr);
    end
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({rsp_valid, psel} !== 2'b00) begin
        bad++; $display("FAIL mid_no_rsp got=%b exp=00", {rsp_valid, psel});
      end
      step();
    end
    run_xfer(32'h0000_0300, 1'b0, 32'h0, 32'hCAFE_F00D, 1, 1'b0, t);
  endtask

  task automatic test_timeout();
    int t;
`ifdef APB_TIMEOUT_EN
    run_xfer(32'h0000_0400, 1'b0, 32'h0, 32'hBAD0_BAD0, 50, 1'b0, t);
    run_xfer(32'h0000_0404, 1'b0, 32'h0, 32'h0F0F_0F0F, TMO - 1, 1'b0, t);
    run_xfer(32'h0000_0408, 1'b1, 32'h1111_2222, 32'h0, TMO, 1'b0, t);
`else
    run_xfer(32'h0000_0400, 1'b0, 32'h0, 32'h600D_600D, 20, 1'b0, t);
`endif
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_master_fsm.md
# apb_master_fsm

RTL APB master for the APB side of the AHB-to-APB bridge. It accepts one transfer request at a time from the bridge core over a valid/ready handshake. It sequences the request through the APB SETUP and ACCESS phases, and returns the read data or completion status as a one-cycle response pulse. It drives the same APB signal set that the APB slave VIP consumes.

## Interface
- APB_BUS_W, 32, width of pwdata/prdata/req_wdata/rsp_rdata
- APB_ADDR_W, 32, width of paddr/req_addr
- TIMEOUT_CYC, 16, ACCESS wait-state limit; used only with APB_TIMEOUT_EN; legal range 1..255
- clk  in  1  single clock; all state changes on posedge
- reset_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_addr  in  APB_ADDR_W  transfer address
- req_write  in  1  1 = write, 0 = read
- req_wdata  in  APB_BUS_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  APB_BUS_W  read data; valid with rsp_valid
- rsp_err  out  1  transfer aborted by timeout; valid with rsp_valid
- paddr  out  APB_ADDR_W  APB address
- pwrite  out  1  APB direction
- pwdata  out  APB_BUS_W  APB write data
- psel  out  1  APB select
- penable  out  1  APB enable
- prdata  in  APB_BUS_W  APB read data
- pready  in  1  APB slave ready

## Operation
- States: IDLE, SETUP, ACCESS. Reset state is IDLE.
- All outputs are registered except req_ready, which is decoded from the state: req_ready = (state == IDLE).
- IDLE:
  - A request is accepted when req_valid && req_ready at a posedge.
  - On acceptance, req_addr and req_write are registered into paddr and pwrite.
  - pwdata is registered from req_wdata for writes and is 0 for reads.
  - The next state is SETUP.
- SETUP: psel=1, penable=0. Unconditionally go to ACCESS after one cycle.
- ACCESS:
  - psel=1, penable=1. paddr, pwrite and pwdata stay stable.
  - When pready=1 at a posedge, the transfer completes:
    - prdata is captured into rsp_rdata for reads; rsp_rdata is 0 for writes.
    - rsp_valid=1 and rsp_err=0 for the next cycle.
    - psel and penable drop to 0; the next state is IDLE.
- paddr, pwrite and pwdata keep their last values in IDLE. Only psel/penable carry phase meaning.
- rsp_valid is high for exactly one cycle per accepted request.
- There is no back-to-back SETUP. At most one transfer is in flight.
- Reset asserted mid-transfer:
  - All outputs go to 0 immediately (asynchronous) and the state goes to IDLE.
  - No response is issued for the aborted transfer.
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready=1 once reset_n is high.

## Timing
- Request accepted at posedge N: SETUP in cycle N+1, ACCESS from cycle N+2.
- With zero wait states, pready=1 is sampled at the posedge ending cycle N+2. rsp_valid is then high in cycle N+3, and req_ready returns high in cycle N+3.
- The minimum request-to-request interval is 3 cycles.
- Each cycle of pready=0 in ACCESS adds exactly one cycle of latency.
- pready and prdata are sampled only in ACCESS. pready=1 in IDLE or SETUP is ignored.
- A request with req_valid=1 in SETUP or ACCESS is not accepted and must be held by the requester.

## Configuration
- Macro APB_TIMEOUT_EN, defined: an 8-bit wait counter controls ACCESS aborts.
  - The counter clears on entry to ACCESS and increments on each ACCESS cycle with pready=0.
  - When the counter reaches TIMEOUT_CYC with pready=0, the transfer is aborted:
    - rsp_valid=1, rsp_err=1 and rsp_rdata=0 in the next cycle.
    - psel and penable drop; the next state is IDLE.
  - If pready=1 on the same edge the limit is reached, normal completion takes priority.
- Macro not defined: no counter is built, ACCESS waits indefinitely, and rsp_err is tied to 0.

## Test plan
- Reset: hold reset_n=0 while driving req_valid=1 -> all outputs 0 and no psel; after release, req_ready=1.
- Zero-wait write of addr 0x0000_0040, data 0xDEAD_BEEF with pready tied high:
  - psel rises one cycle after acceptance and penable one cycle later.
  - paddr and pwdata equal the request values.
  - rsp_valid=1 for one cycle, 3 cycles after acceptance, with rsp_err=0.
- Read of 0x0000_0010 with pready low for 3 ACCESS cycles, then high with prdata=0x1234_5678:
  - ACCESS lasts 4 cycles.
  - rsp_rdata=0x1234_5678 with rsp_valid.
  - req_ready stays low from acceptance until the rsp_valid cycle.
- Back-to-back: req_valid held high for 4 requests -> 4 responses, each transfer 3 cycles apart, paddr stable throughout each ACCESS.
- Reset mid-ACCESS: assert reset_n=0 during a wait state -> psel and penable drop asynchronously, no rsp_valid, next request runs normally.
- With APB_TIMEOUT_EN and TIMEOUT_CYC=4, pready held low:
  - Abort after 4 ACCESS cycles with rsp_err=1 and rsp_rdata=0.
  - Repeat with pready=1 on the 4th cycle -> normal completion with rsp_err=0.
